kr_seq: RTL
===========

// Module: kr_seq
// PURPOSE
//  Sequential PRESENT-80 key-schedule engine. Holds the 80-bit key register
//  and instantiates the combinational round-key update `kr` in its feedback path.
//  Accepts one master key, then streams the 32 round keys RK1..RK32 (64 bits each)
//  to the datapath, one per out handshake. Sits directly upstream of the round datapath.
// PARAMETERS
//  NRND   32  number of round keys emitted per key load (fixed by PRESENT-80; not user-tunable)
// PORTS
//  clk       in   1     single clock, all state updates on posedge
//  rst       in   1     synchronous, active-high reset
//  in_valid  in   1     master key present on key_in
//  in_ready  out  1     block can accept a new master key
//  key_in    in   80    master key, [0:79], bit 0 = MSB
//  out_valid out  1     rk/rk_idx hold a valid round key
//  out_ready in   1     consumer takes the round key this cycle
//  rk        out  64    current round key = kreg[0:63]
//  rk_idx    out  6     round index of rk, 1..32
//  done      out  1     one-cycle pulse after RK32 is accepted
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, kreg=0, rnd=0, done=0.
//    Then in_ready=1, out_valid=0, rk=0, rk_idx=0.
//    Reset wins over every other input, including mid-schedule; the schedule is abandoned.
//  - State IDLE:
//    in_ready=1, out_valid=0.
//    On in_valid&in_ready: kreg<=key_in, rnd<=1, state<=RUN.
//  - State RUN:
//    in_ready=0; in_valid ignored, key_in not sampled.
//    out_valid=1, rk=kreg[0:63], rk_idx=rnd.
//  - RUN handshake (out_valid&out_ready):
//    rnd<32: kreg<=kr(kinp=kreg, cnt=rnd[1:5]), rnd<=rnd+1.
//    rnd==32: state<=IDLE, done<=1 for one cycle. kreg and rnd hold their values; rk/rk_idx
//    read 0 in IDLE.
//  - Stall: out_valid=1 & out_ready=0 -> kreg, rnd and rk stay stable (AXI-style, no drop).
//  - cnt to kr is the 5-bit round counter 1..31. rnd never wraps; 32 is the terminal value.
//  - Latency:
//    key accept -> RK1 valid the next cycle.
//    Full stream = 32 cycles with out_ready tied high.
//    in_ready rises the cycle after RK32 is accepted; there is no same-cycle reload.
//    Minimum key-to-key period is 33 cycles.
//  - out_valid, in_ready and done are functions of registered state only; there are no
//    combinational paths from in_valid/out_ready.
// CONFIGURATION
//  KR_SEQ_FINAL_KEY_EN defined:
//   - Adds output kfin (80 bits) and kfin_valid (1 bit).
//   - On acceptance of RK32, kfin<=kr(kreg,31)-equivalent final register content (=K32, full
//     80 bits) and kfin_valid<=1. This is used to seed the decryption key setup.
//   - kfin_valid clears on the next key accept or on rst; kfin resets to 0.
//  Macro undefined: kfin and kfin_valid ports and their register are absent; all other
//  behaviour is identical.
// TESTING
//  1 rst=1 for 2 cycles -> in_ready=1, out_valid=0, rk=0, rk_idx=0, done=0.
//  2 key_in=0, accept, out_ready=1 -> RK1=0x0000000000000000, RK2=0xC000000000000000,
//    RK3=0x5000180000000001. done pulses exactly once, 32 cycles after accept.
//  3 Same key, out_ready toggled randomly (50%) -> identical 32-key sequence versus scenario 2.
//    rk is stable while stalled, and rk_idx increments by 1 per handshake only.
//  4 in_valid held high with a different key during RUN -> it is ignored; the stream stays
//    that of the first key; in_ready=0 until the cycle after RK32.
//  5 rst asserted at rk_idx=17 -> next cycle IDLE, out_valid=0. A new key_in=0xFFFF..FF
//    restarts at rk_idx=1 with RK1=0xFFFFFFFFFFFFFFFF.
//  6 [KR_SEQ_FINAL_KEY_EN] zero key, full run -> kfin_valid=1 after done, kfin[0:63]=RK32.
//    kfin_valid drops on the next accept.

Source files
------------

// File: rtl/kr_seq_if.sv
// Handshake bundle between the PRESENT-80 key-schedule engine and its neighbours.
// KR_SEQ_FINAL_KEY_EN adds the final-key outputs used to seed decryption key setup.
interface kr_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] key_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] rk;
  logic [5:0]  rk_idx;
  logic        done;
`ifdef KR_SEQ_FINAL_KEY_EN
  logic [79:0] kfin;
  logic        kfin_valid;
`endif

  modport slave (
    input  in_valid, key_in, out_ready,
    output in_ready, out_valid, rk, rk_idx, done
`ifdef KR_SEQ_FINAL_KEY_EN
    , output kfin, kfin_valid
`endif
  );

  modport master (
    output in_valid, key_in, out_ready,
    input  in_ready, out_valid, rk, rk_idx, done
`ifdef KR_SEQ_FINAL_KEY_EN
    , input kfin, kfin_valid
`endif
  );
endinterface

// File: rtl/kr_seq.sv
// PRESENT-80 key-schedule engine: loads one master key, streams RK1..RK32 on a valid/ready port.
// Optional KR_SEQ_FINAL_KEY_EN keeps the final 80-bit key register (K32) for decryption setup.
//
// state | meaning
// IDLE  | waiting for a master key, in_ready=1
// RUN   | presenting round key rk_idx, waiting for out_ready
module kr_seq (
  input  logic     clk,
  input  logic     rst,
  kr_seq_if.slave  bus
);

  localparam logic [5:0] NRND = 6'd32;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [79:0] kreg_q, kreg_d;
  logic [5:0]  rnd_q, rnd_d;
  logic        done_q, done_d;
`ifdef KR_SEQ_FINAL_KEY_EN
  logic [79:0] kfin_q, kfin_d;
  logic        kfin_valid_q, kfin_valid_d;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Round-key update: rotate left 61, S-box on the top nibble, counter into bits 19..15.
  function automatic logic [79:0] kr(input logic [79:0] kinp, input logic [4:0] cnt);
    logic [79:0] r;
    r          = {kinp[18:0], kinp[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ cnt;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
`ifdef KR_SEQ_FINAL_KEY_EN
    kfin_d       = kfin_q;
    kfin_valid_d = kfin_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          kreg_d  = bus.key_in;
          rnd_d   = 6'd1;
          state_d = RUN;
`ifdef KR_SEQ_FINAL_KEY_EN
          kfin_valid_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (bus.out_ready) begin
          if (rnd_q == NRND) begin
            // kreg/rnd hold after the last key; outputs are masked in IDLE.
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef KR_SEQ_FINAL_KEY_EN
            kfin_d       = kreg_q;
            kfin_valid_d = 1'b1;
`endif
          end else begin
            kreg_d = kr(kreg_q, rnd_q[4:0]);
            rnd_d  = rnd_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kreg_q  <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
`ifdef KR_SEQ_FINAL_KEY_EN
      kfin_q       <= '0;
      kfin_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      kreg_q  <= kreg_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
`ifdef KR_SEQ_FINAL_KEY_EN
      kfin_q       <= kfin_d;
      kfin_valid_q <= kfin_valid_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == RUN);
  assign bus.rk        = (state_q == RUN) ? kreg_q[79:16] : 64'd0;
  assign bus.rk_idx    = (state_q == RUN) ? rnd_q : 6'd0;
  assign bus.done      = done_q;
`ifdef KR_SEQ_FINAL_KEY_EN
  assign bus.kfin       = kfin_q;
  assign bus.kfin_valid = kfin_valid_q;
`endif

endmodule
